// File: rtl/grid_cell_store.sv
// grid_cell_store: 32x24 play-field cell map with sweep clear,
// controller read/write port and registered display lookup.
module grid_cell_store #(
    parameter int GRID_X  = 32,
    parameter int GRID_Y  = 24,
    parameter int CELL_PX = 32,
    parameter int WALLS   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [35:0] rect_write,
    input  logic [31:0] rect_read_addr,
    output logic [3:0]  rect_read_data,
    input  logic        clear,
    output logic        busy,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    output logic [3:0]  disp_cell
);

    localparam int CELLS = GRID_X * GRID_Y;
    localparam int SH    = $clog2(CELL_PX);
    localparam logic [35:0] SENT = 36'hF_FFFF_FFFF;
    localparam logic [3:0]  C_NULL = 4'h0;
    localparam logic [3:0]  C_ROCK = 4'h2;

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t      state;
    logic [9:0]  cnt;
    logic [35:0] last_wr;
    logic [3:0]  mem [CELLS];

    logic [15:0] wx, wy, rx, ry;
    logic [3:0]  wt;
    logic        we;
    logic [9:0]  waddr;
    logic [3:0]  wdata;
    logic [10:0] dh, dv;
    logic        d_in;

    function automatic logic in_range(logic [15:0] x, logic [15:0] y);
        return (x < 16'(GRID_X)) && (y < 16'(GRID_Y));
    endfunction

    function automatic logic on_border(logic [4:0] x, logic [4:0] y);
        return (WALLS != 0) &&
               (x == 5'd0 || x == 5'(GRID_X - 1) ||
                y == 5'd0 || y == 5'(GRID_Y - 1));
    endfunction

    assign wx = rect_write[35:20];
    assign wy = rect_write[19:4];
    assign wt = rect_write[3:0];
    assign rx = rect_read_addr[31:16];
    assign ry = rect_read_addr[15:0];

    assign dh   = hcount >> SH;
    assign dv   = vcount >> SH;
    assign d_in = (hcount < 11'(GRID_X * CELL_PX)) &&
                  (vcount < 11'(GRID_Y * CELL_PX));

    logic unused_disp;
    assign unused_disp = ^{dh[10:5], dv[10:5]};

    // A held command only commits on the cycle it differs from last_wr.
    always_comb begin
        we    = 1'b0;
        waddr = cnt;
        wdata = C_NULL;
        if (!rst && !clear) begin
            if (state == S_CLEAR) begin
                we    = 1'b1;
                waddr = cnt;
                wdata = on_border(cnt[4:0], cnt[9:5]) ? C_ROCK : C_NULL;
            end else if (rect_write != last_wr &&
                         in_range(wx, wy) &&
                         !on_border(wx[4:0], wy[4:0])) begin
                we    = 1'b1;
                waddr = {wy[4:0], wx[4:0]};
                wdata = wt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_comb begin
        rect_read_data = C_NULL;
        if (state == S_RUN)
            rect_read_data = in_range(rx, ry) ?
                             mem[{ry[4:0], rx[4:0]}] : C_ROCK;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_CLEAR;
            cnt       <= '0;
            busy      <= 1'b1;
            last_wr   <= SENT;
            disp_cell <= C_NULL;
        end else begin
            disp_cell <= (state == S_RUN && d_in) ?
                         mem[{dv[4:0], dh[4:0]}] : C_NULL;
            if (clear) begin
                state   <= S_CLEAR;
                cnt     <= '0;
                busy    <= 1'b1;
                last_wr <= SENT;
            end else if (state == S_CLEAR) begin
                last_wr <= SENT;
                if (cnt == 10'(CELLS - 1)) begin
                    state <= S_RUN;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 10'd1;
                end
            end else begin
                last_wr <= rect_write;
            end
        end
    end

endmodule

// File: tb/tb_grid_cell_store.sv
// tb_grid_cell_store: directed checks of sweep, write, read,
// border protection, display lookup and clear restart.
module tb_grid_cell_store;

    localparam logic [35:0] IDLE = 36'hF_FFFF_FFF0;

    logic        clk = 1'b0;
    logic        rst;
    logic [35:0] rect_write;
    logic [31:0] rect_read_addr;
    logic [3:0]  rect_read_data;
    logic        clear;
    logic        busy;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic [3:0]  disp_cell;

    int checks   = 0;
    int failures = 0;

    grid_cell_store dut (
        .clk            (clk),
        .rst            (rst),
        .rect_write     (rect_write),
        .rect_read_addr (rect_read_addr),
        .rect_read_data (rect_read_data),
        .clear          (clear),
        .busy           (busy),
        .hcount         (hcount),
        .vcount         (vcount),
        .disp_cell      (disp_cell)
    );

    always #5 clk = ~clk;

    function automatic logic [35:0] wcmd(int x, int y, logic [3:0] t);
        return {16'(x), 16'(y), t};
    endfunction

    function automatic logic [31:0] radr(int x, int y);
        return {16'(x), 16'(y)};
    endfunction

    task automatic peek(input int x, input int y, output logic [3:0] v);
        rect_read_addr = radr(x, y);
        #1;
        v = rect_read_data;
    endtask

    task automatic test_reset;
        int n;
        logic [3:0] v;
        rst = 1'b1;
        clear = 1'b0;
        rect_write = IDLE;
        rect_read_addr = radr(32, 0);
        hcount = 11'd0;
        vcount = 11'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_busy got=%0b exp=1", busy);
        end
        checks++;
        if (disp_cell !== 4'h0) begin
            failures++;
            $display("FAIL reset_disp got=%0h exp=0", disp_cell);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (rect_read_data !== 4'h0) begin
            failures++;
            $display("FAIL sweep_read_forced got=%0h exp=0", rect_read_data);
        end
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != 768) begin
            failures++;
            $display("FAIL sweep_len got=%0d exp=768", n);
        end
        @(negedge clk);
        peek(0, 0, v);
        checks++;
        if (v !== 4'h2) begin
            failures++;
            $display("FAIL cell_0_0 got=%0h exp=2", v);
        end
        peek(31, 23, v);
        checks++;
        if (v !== 4'h2) begin
            failures++;
            $display("FAIL cell_31_23 got=%0h exp=2", v);
        end
        peek(15, 15, v);
        checks++;
        if (v !== 4'h0) begin
            failures++;
            $display("FAIL cell_15_15 got=%0h exp=0", v);
        end
        peek(0, 10, v);
        checks++;
        if (v !== 4'h2) begin
            failures++;
            $display("FAIL cell_0_10 got=%0h exp=2", v);
        end
    endtask

    task automatic test_write_commit;
        logic [3:0] v;
        @(negedge clk);
        rect_write = wcmd(5, 7, 4'h1);
        rect_read_addr = radr(5, 7);
        #1;
        checks++;
        if (rect_read_data !== 4'h0) begin
            failures++;
            $display("FAIL raw_old got=%0h exp=0", rect_read_data);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rect_read_data !== 4'h1) begin
            failures++;
            $display("FAIL commit got=%0h exp=1", rect_read_data);
        end
        repeat (9) @(posedge clk);
        @(negedge clk);
        rect_write = IDLE;
        peek(5, 7, v);
        checks++;
        if (v !== 4'h1) begin
            failures++;
            $display("FAIL held got=%0h exp=1", v);
        end
    endtask

    task automatic test_out_of_range;
        logic [3:0] v;
        @(negedge clk);
        rect_write = wcmd(65535, 3, 4'h1);
        @(negedge clk);
        rect_write = wcmd(37, 3, 4'h1);
        @(negedge clk);
        rect_write = wcmd(5, 35, 4'h1);
        @(negedge clk);
        rect_write = IDLE;
        @(negedge clk);
        peek(31, 3, v);
        checks++;
        if (v !== 4'h2) begin
            failures++;
            $display("FAIL oor_ffff got=%0h exp=2", v);
        end
        peek(5, 3, v);
        checks++;
        if (v !== 4'h0) begin
            failures++;
            $display("FAIL oor_alias got=%0h exp=0", v);
        end
        peek(32, 0, v);
        checks++;
        if (v !== 4'h2) begin
            failures++;
            $display("FAIL rd_x32 got=%0h exp=2", v);
        end
        peek(0, 24, v);
        checks++;
        if (v !== 4'h2) begin
            failures++;
            $display("FAIL rd_y24 got=%0h exp=2", v);
        end
        peek(37, 3, v);
        checks++;
        if (v !== 4'h2) begin
            failures++;
            $display("FAIL rd_x37 got=%0h exp=2", v);
        end
    endtask

    task automatic test_border;
        logic [3:0] v;
        @(negedge clk);
        rect_write = wcmd(0, 10, 4'h0);
        @(negedge clk);
        rect_write = wcmd(31, 5, 4'h4);
        @(negedge clk);
        rect_write = wcmd(7, 23, 4'h1);
        @(negedge clk);
        rect_write = IDLE;
        @(negedge clk);
        peek(0, 10, v);
        checks++;
        if (v !== 4'h2) begin
            failures++;
            $display("FAIL border_0_10 got=%0h exp=2", v);
        end
        peek(31, 5, v);
        checks++;
        if (v !== 4'h2) begin
            failures++;
            $display("FAIL border_31_5 got=%0h exp=2", v);
        end
        peek(7, 23, v);
        checks++;
        if (v !== 4'h2) begin
            failures++;
            $display("FAIL border_7_23 got=%0h exp=2", v);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] v;
        @(negedge clk);
        rect_write = wcmd(10, 10, 4'h1);
        @(negedge clk);
        rect_write = wcmd(11, 10, 4'h4);
        @(negedge clk);
        rect_write = wcmd(12, 10, 4'h2);
        @(negedge clk);
        rect_write = wcmd(13, 10, 4'h9);
        @(negedge clk);
        rect_write = IDLE;
        peek(10, 10, v);
        checks++;
        if (v !== 4'h1) begin
            failures++;
            $display("FAIL b2b_10 got=%0h exp=1", v);
        end
        peek(11, 10, v);
        checks++;
        if (v !== 4'h4) begin
            failures++;
            $display("FAIL b2b_11 got=%0h exp=4", v);
        end
        peek(12, 10, v);
        checks++;
        if (v !== 4'h2) begin
            failures++;
            $display("FAIL b2b_12 got=%0h exp=2", v);
        end
        peek(13, 10, v);
        checks++;
        if (v !== 4'h9) begin
            failures++;
            $display("FAIL b2b_13 got=%0h exp=9", v);
        end
    endtask

    task automatic test_display;
        @(negedge clk);
        rect_write = wcmd(3, 2, 4'h4);
        hcount = 11'd0;
        vcount = 11'd0;
        @(negedge clk);
        rect_write = IDLE;
        checks++;
        if (disp_cell !== 4'h2) begin
            failures++;
            $display("FAIL disp_0_0 got=%0h exp=2", disp_cell);
        end
        hcount = 11'd100;
        vcount = 11'd70;
        #1;
        checks++;
        if (disp_cell !== 4'h2) begin
            failures++;
            $display("FAIL disp_latency got=%0h exp=2", disp_cell);
        end
        @(negedge clk);
        checks++;
        if (disp_cell !== 4'h4) begin
            failures++;
            $display("FAIL disp_3_2 got=%0h exp=4", disp_cell);
        end
        hcount = 11'd1030;
        @(negedge clk);
        checks++;
        if (disp_cell !== 4'h0) begin
            failures++;
            $display("FAIL disp_h1030 got=%0h exp=0", disp_cell);
        end
        hcount = 11'd100;
        vcount = 11'd770;
        @(negedge clk);
        checks++;
        if (disp_cell !== 4'h0) begin
            failures++;
            $display("FAIL disp_v770 got=%0h exp=0", disp_cell);
        end
        hcount = 11'd1023;
        vcount = 11'd767;
        @(negedge clk);
        checks++;
        if (disp_cell !== 4'h2) begin
            failures++;
            $display("FAIL disp_corner got=%0h exp=2", disp_cell);
        end
    endtask

    task automatic test_clear_mid;
        int n;
        logic [3:0] v;
        @(negedge clk);
        rect_write = wcmd(8, 8, 4'h1);
        @(negedge clk);
        peek(8, 8, v);
        checks++;
        if (v !== 4'h1) begin
            failures++;
            $display("FAIL snake_pre got=%0h exp=1", v);
        end
        @(negedge clk);
        rect_write = wcmd(6, 6, 4'h4);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL clear_busy got=%0b exp=1", busy);
        end
        repeat (400) @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        rect_read_addr = radr(0, 0);
        hcount = 11'd0;
        vcount = 11'd0;
        #1;
        checks++;
        if (rect_read_data !== 4'h0) begin
            failures++;
            $display("FAIL clear_read_forced got=%0h exp=0", rect_read_data);
        end
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 5) begin
                checks++;
                if (disp_cell !== 4'h0) begin
                    failures++;
                    $display("FAIL clear_disp_forced got=%0h exp=0", disp_cell);
                end
            end
        end
        checks++;
        if (n != 768) begin
            failures++;
            $display("FAIL restart_len got=%0d exp=768", n);
        end
        @(negedge clk);
        @(negedge clk);
        rect_write = IDLE;
        peek(8, 8, v);
        checks++;
        if (v !== 4'h0) begin
            failures++;
            $display("FAIL snake_cleared got=%0h exp=0", v);
        end
        peek(6, 6, v);
        checks++;
        if (v !== 4'h4) begin
            failures++;
            $display("FAIL held_after_sweep got=%0h exp=4", v);
        end
        peek(0, 0, v);
        checks++;
        if (v !== 4'h2) begin
            failures++;
            $display("FAIL wall_after_clear got=%0h exp=2", v);
        end
    endtask

    initial begin
        test_reset();
        test_write_commit();
        test_out_of_range();
        test_border();
        test_back_to_back();
        test_display();
        test_clear_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
